cpu_io_mux: RTL and testbench

//  Parametrised Z80 I/O port decoder/dispatcher; successor to the fixed two-target CPU bus front end.

---
 rtl/cpu_io_pkg.sv | 26 ++
 rtl/cpu_io_mux_if.sv | 37 +++
 rtl/bus_sync.sv | 42 ++++
 rtl/cpu_io_mux.sv | 146 ++++++++++++++
 tb/tb_cpu_io_mux.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_io_pkg
//  Description : Shared types, constants and address-decode helper for the
//                Z80 I/O port dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_io_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRIVE = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [7:0] IDLE_DATA = 8'hFF;

    // Window match: only the address bits above the port field are compared.
    function automatic logic decode_hit(input logic [7:0] a, input logic [7:0] base, input int pb);
        return (a >> pb) == (base >> pb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_io_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_io_mux_if
//  Description : CPU pin side and peripheral channel side of the I/O mux.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_io_mux_if #(
    parameter int NUM_CH    = 4,
    parameter int PORT_BITS = 2
);
    logic [7:0]           A;
    logic                 iorq_n;
    logic                 rd_n;
    logic                 wr_n;
    logic [7:0]           cd_in;
    logic [7:0]           cd_out;
    logic                 cd_oe;
    logic                 cs_n;
    logic [NUM_CH-1:0]    ch_req;
    logic                 ch_wr;
    logic [PORT_BITS-1:0] ch_port;
    logic [7:0]           ch_wdata;
    logic [NUM_CH-1:0]    ch_ack;
    logic [NUM_CH*8-1:0]  ch_rdata;
    logic                 timeout_err;

    modport master (
        output A, iorq_n, rd_n, wr_n, cd_in, ch_ack, ch_rdata,
        input  cd_out, cd_oe, cs_n, ch_req, ch_wr, ch_port, ch_wdata, timeout_err
    );

    modport slave (
        input  A, iorq_n, rd_n, wr_n, cd_in, ch_ack, ch_rdata,
        output cd_out, cd_oe, cs_n, ch_req, ch_wr, ch_port, ch_wdata, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/bus_sync.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sync
//  Description : W-bit multi-flop synchroniser with registered level and
//                rise/fall pulses, all three aligned to the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic [W-1:0] i_d,
    output logic      [W-1:0] o_q,
    output logic      [W-1:0] o_rise,
    output logic      [W-1:0] o_fall
);
    logic [STAGES-1:0][W-1:0] r_pipe;
    logic [W-1:0]             r_q;
    logic [W-1:0]             r_rise;
    logic [W-1:0]             r_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe <= '0;
            r_q    <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_pipe <= {r_pipe[STAGES-2:0], i_d};
            r_q    <= r_pipe[STAGES-1];
            r_rise <= r_pipe[STAGES-1] & ~r_q;
            r_fall <= ~r_pipe[STAGES-1] & r_q;
        end
    end

    assign o_q    = r_q;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
endmodule
`default_nettype wire

// File: rtl/cpu_io_mux.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_io_mux
//  Description : Z80 I/O port decoder/dispatcher: synchronises CPU strobes,
//                decodes NUM_CH port windows, issues one request per bus
//                cycle and returns read data with a bounded wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_io_mux
    import cpu_io_pkg::*;
#(
    parameter int                       NUM_CH      = 4,
    parameter int                       PORT_BITS   = 2,
    parameter logic [NUM_CH-1:0][7:0]   BASE_ADDR   = {8'hA4, 8'hA0, 8'h9C, 8'h98},
    parameter int                       SYNC_STAGES = 2,
    parameter int                       TIMEOUT     = 15
) (
    input  wire logic   clk,
    input  wire logic   reset,
    cpu_io_mux_if.slave bus
);
    localparam int              c_tmr_w = $clog2(TIMEOUT + 1);
    localparam int              c_idx_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [c_tmr_w-1:0] c_tmo = c_tmr_w'(TIMEOUT);

    // Bit 0 = read strobe, bit 1 = write strobe.
    logic [1:0] w_lvl, w_rise, w_fall, w_prev;
    logic       w_start;

    bus_sync #(.W(2), .STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_d    ({~(bus.iorq_n | bus.wr_n), ~(bus.iorq_n | bus.rd_n)}),
        .o_q    (w_lvl),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Reconstruct the previous level so the start edge is taken on rd^wr.
    assign w_prev  = (w_lvl & ~w_rise) | w_fall;
    assign w_start = (w_lvl[0] ^ w_lvl[1]) & ~(w_prev[0] ^ w_prev[1]);

    logic               w_hit;
    logic [c_idx_w-1:0] w_hit_idx;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (decode_hit(bus.A, BASE_ADDR[k], PORT_BITS)) begin
                w_hit     = 1'b1;
                w_hit_idx = c_idx_w'(k);
            end
        end
    end

    state_t               r_state, w_next;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_wr;
    logic [PORT_BITS-1:0] r_port;
    logic [7:0]           r_wdata;
    logic [7:0]           r_cd_out;
    logic [c_tmr_w-1:0]   r_timer;
    logic                 r_err;
    logic                 w_ack;
    logic [7:0]           w_rdata;

    assign w_ack   = bus.ch_ack[r_idx];
    assign w_rdata = bus.ch_rdata[{r_idx, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start && w_hit) w_next = REQ;
            REQ:     if (r_wr)             w_next = HOLD;
                     else if (!w_lvl[0])   w_next = IDLE;
                     else                  w_next = WAIT;
            WAIT:    if (!w_lvl[0])        w_next = IDLE;
                     else if (w_ack)       w_next = DRIVE;
                     else if (r_timer == c_tmo) w_next = DRIVE;
            DRIVE:   if (!w_lvl[0])        w_next = IDLE;
            HOLD:    if (!w_lvl[1])        w_next = IDLE;
            default:                       w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx    <= '0;
            r_wr     <= 1'b0;
            r_port   <= '0;
            r_wdata  <= '0;
            r_cd_out <= '0;
            r_timer  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_start && w_hit) begin
                    r_idx   <= w_hit_idx;
                    r_wr    <= ~w_lvl[0];
                    r_port  <= bus.A[PORT_BITS-1:0];
                    r_wdata <= bus.cd_in;
                end
                REQ:  r_timer <= '0;
                WAIT: if (w_lvl[0]) begin
                    // Ack on the final timer cycle still beats the timeout.
                    if (w_ack) begin
                        r_cd_out <= w_rdata;
                    end else if (r_timer == c_tmo) begin
                        r_cd_out <= IDLE_DATA;
                        r_err    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [NUM_CH-1:0] w_req;
    logic              w_cd_oe;
    logic              w_cs_n;

    always_comb begin
        w_req = '0;
        if (r_state == REQ) w_req[r_idx] = 1'b1;
        w_cd_oe = (r_state == DRIVE);
        w_cs_n  = (r_state == IDLE);
    end

    assign bus.ch_req      = w_req;
    assign bus.ch_wr       = r_wr;
    assign bus.ch_port     = r_port;
    assign bus.ch_wdata    = r_wdata;
    assign bus.cd_out      = r_cd_out;
    assign bus.cd_oe       = w_cd_oe;
    assign bus.cs_n        = w_cs_n;
    assign bus.timeout_err = r_err;
endmodule
`default_nettype wire

// File: tb/tb_cpu_io_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_io_mux
//  Description : Directed self-checking bench for cpu_io_mux with a
//                cycle-window reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_io_mux;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_io_mux_if #(.NUM_CH(4), .PORT_BITS(2)) bus ();

    cpu_io_mux #(
        .NUM_CH      (4),
        .PORT_BITS   (2),
        .BASE_ADDR   ({8'hA4, 8'hA0, 8'h9C, 8'h98}),
        .SYNC_STAGES (2),
        .TIMEOUT     (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: channel windows and the edges each output is active.
    logic [7:0] bases [4] = '{8'h98, 8'h9C, 8'hA0, 8'hA4};
    int         m_req_at = -1, m_busy_from = 0, m_busy_to = 0;
    int         m_oe_from = 0, m_oe_to = 0, m_err_from = BIG, m_err_to = BIG;
    logic [3:0] m_req_vec = '0;
    logic       m_wr = 1'b0;
    logic [1:0] m_port = '0;
    logic [7:0] m_wdata = '0, m_cd_out = '0;

    function automatic int model_ch(input logic [7:0] a);
        for (int k = 0; k < 4; k++) if (a[7:2] == bases[k][7:2]) return k;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("cs_n",  bus.cs_n,  (cyc >= m_busy_from && cyc < m_busy_to) ? 0 : 1);
            chk("cd_oe", bus.cd_oe, (cyc >= m_oe_from && cyc < m_oe_to) ? 1 : 0);
            chk("ch_req", bus.ch_req, (cyc == m_req_at) ? m_req_vec : 4'b0);
            chk("timeout_err", bus.timeout_err, (cyc >= m_err_from && cyc < m_err_to) ? 1 : 0);
            if (cyc == m_req_at) begin
                chk("ch_wr", bus.ch_wr, m_wr);
                chk("ch_port", bus.ch_port, m_port);
                if (m_wr) chk("ch_wdata", bus.ch_wdata, m_wdata);
            end
            if (cyc >= m_oe_from && cyc < m_oe_to) chk("cd_out", bus.cd_out, m_cd_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_windows();
        m_req_at = -1; m_busy_from = 0; m_busy_to = 0; m_oe_from = 0; m_oe_to = 0;
    endtask

    // mode 0: normal release, 1: release rd after hold edges, 2: reset hold edges into DRIVE.
    task automatic do_read(input logic [7:0] addr, input int d, input logic [7:0] data,
                           input int hold, input int mode,
                           output logic [3:0] cap_req, output logic [1:0] cap_port,
                           output logic [7:0] cap_out);
        int t0, k, drv, ack_at, rel_at, end_at;
        bit timed_out;
        t0 = cyc; k = model_ch(addr);
        cap_req = '0; cap_port = '0; cap_out = '0;
        clear_windows();
        drv = -1; ack_at = -1;
        timed_out = (d < 0 || d > 15);
        if (k < 0) begin
            rel_at = t0 + hold; end_at = rel_at + 7;
        end else begin
            m_req_at = t0 + 4; m_req_vec = 4'(1 << k); m_wr = 1'b0; m_port = addr[1:0];
            m_busy_from = t0 + 4;
            if (!timed_out) ack_at = t0 + 5 + d;
            if (mode == 1) begin
                rel_at = t0 + hold; m_busy_to = rel_at + 4;
                end_at = ((ack_at > rel_at + 4) ? ack_at : rel_at + 4) + 3;
            end else begin
                drv = t0 + 6 + (timed_out ? 15 : d);
                m_oe_from = drv; m_cd_out = timed_out ? 8'hFF : data;
                if (timed_out) begin m_err_from = drv; m_err_to = BIG; end
                rel_at = drv + hold;
                if (mode == 2) begin
                    m_busy_to = rel_at + 1; m_oe_to = rel_at + 1; m_err_to = rel_at + 1;
                end else begin
                    m_busy_to = rel_at + 4; m_oe_to = rel_at + 4;
                end
                end_at = rel_at + 7;
            end
        end
        bus.A = addr; bus.cd_in = 8'h00; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
        while (cyc < end_at) begin
            tick();
            bus.ch_ack = '0;
            if (cyc == ack_at) begin
                bus.ch_ack[k] = 1'b1;
                bus.ch_rdata[8*k +: 8] = data;
            end
            if (cyc == m_req_at) begin cap_req = bus.ch_req; cap_port = bus.ch_port; end
            if (cyc == drv) cap_out = bus.cd_out;
            if (cyc == rel_at) begin
                bus.rd_n = 1'b1; bus.iorq_n = 1'b1;
                if (mode == 2) reset = 1'b1;
            end
            if (mode == 2 && cyc == rel_at + 4) reset = 1'b0;
        end
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input int hold,
                            output logic [3:0] cap_req, output logic [1:0] cap_port,
                            output logic [7:0] cap_wdata, output logic cap_wr);
        int t0, k, rel_at;
        t0 = cyc; k = model_ch(addr);
        clear_windows();
        cap_req = '0; cap_port = '0; cap_wdata = '0; cap_wr = 1'b0;
        m_req_at = t0 + 4; m_req_vec = 4'(1 << k); m_wr = 1'b1; m_port = addr[1:0]; m_wdata = data;
        rel_at = t0 + hold; m_busy_from = t0 + 4; m_busy_to = rel_at + 4;
        bus.A = addr; bus.cd_in = data; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        while (cyc < rel_at + 7) begin
            tick();
            bus.ch_ack = '0;
            if (cyc == t0 + 6) bus.ch_ack[k] = 1'b1;   // ignored while posting a write
            if (cyc == m_req_at) begin
                cap_req = bus.ch_req; cap_port = bus.ch_port; cap_wdata = bus.ch_wdata; cap_wr = bus.ch_wr;
            end
            if (cyc == rel_at) begin bus.wr_n = 1'b1; bus.iorq_n = 1'b1; end
        end
    endtask

    task automatic do_both(input logic [7:0] addr, input int hold);
        int t0;
        t0 = cyc;
        clear_windows();
        bus.A = addr; bus.iorq_n = 1'b0; bus.rd_n = 1'b0; bus.wr_n = 1'b0;
        while (cyc < t0 + hold + 7) begin
            tick();
            if (cyc == t0 + hold) begin bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.iorq_n = 1'b1; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rq;
        logic [1:0] pt;
        logic [7:0] od;
        logic       wr;
        bus.A = '0; bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
        bus.cd_in = '0; bus.ch_ack = '0; bus.ch_rdata = '0;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_cd_out", bus.cd_out, 8'h00);
        chk("rst_cs_n", bus.cs_n, 1);
        chk("rst_ch_wdata", bus.ch_wdata, 8'h00);
        reset = 1'b0;
        repeat (2) tick();

        do_read(8'h99, 3, 8'h5A, 4, 0, rq, pt, od);
        chk("rd99_req", rq, 4'b0001);
        chk("rd99_port", pt, 2'd1);
        chk("rd99_data", od, 8'h5A);

        do_write(8'hA6, 8'hC3, 8, rq, pt, od, wr);
        chk("wrA6_req", rq, 4'b1000);
        chk("wrA6_port", pt, 2'd2);
        chk("wrA6_wdata", od, 8'hC3);
        chk("wrA6_wr", wr, 1);

        do_read(8'hA1, -1, 8'h00, 3, 0, rq, pt, od);
        chk("toA1_req", rq, 4'b0100);
        chk("toA1_data", od, 8'hFF);
        chk("toA1_err", bus.timeout_err, 1);

        do_read(8'h10, 0, 8'h00, 8, 0, rq, pt, od);
        do_both(8'h99, 8);

        do_read(8'h98, 5, 8'h11, 2, 1, rq, pt, od);
        chk("early_req", rq, 4'b0001);
        chk("early_err_sticky", bus.timeout_err, 1);

        do_read(8'h9D, 2, 8'h3C, 2, 2, rq, pt, od);
        chk("rst_drive_data", od, 8'h3C);
        chk("rst_clears_err", bus.timeout_err, 0);

        do_read(8'h9E, 0, 8'hE7, 2, 0, rq, pt, od);
        chk("rd9E_req", rq, 4'b0010);
        chk("rd9E_port", pt, 2'd2);
        chk("rd9E_data", od, 8'hE7);

        do_read(8'hA4, 15, 8'h81, 2, 0, rq, pt, od);
        chk("edge_ack_data", od, 8'h81);
        chk("edge_ack_noerr", bus.timeout_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
